fetch_pc_queue: RTL and testbench

Front-end fetch stage that sits directly upstream of decode and the branch execution unit. It owns the fetch PC and issues in-order word fetches to the instruction memory port over a valid/ready handshake. Returned words are buffered in a small FIFO for decode. A redirect from the execute stage (a mispredict or a taken jump) flushes the queue and discards stale in-flight responses.

---
 rtl/fetch_pc_queue.sv | 160 ++++++++++++++++
 tb/tb_fetch_pc_queue.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_queue.sv
// Fetch stage: owns the fetch PC, issues in-order word fetches and buffers returned words for decode.
// Optional macro FETCH_BYPASS_EN forwards a response straight to decode when the FIFO is empty.
module fetch_pc_queue #(
    parameter int              ALEN            = 32,
    parameter logic [ALEN-1:0] RESET_PC        = '0,
    parameter int              FIFO_DEPTH      = 4,
    parameter int              MAX_OUTSTANDING = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [ALEN-1:0] redirect_target,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [ALEN-1:0] mem_req_addr,
    input  logic            mem_resp_valid,
    input  logic [31:0]     mem_resp_data,
    input  logic            mem_resp_error,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ALEN-1:0] out_addr,
    output logic [31:0]     out_data,
    output logic            out_half_start,
    output logic            out_fault
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int SW = ((CW > OW) ? CW : OW) + 1;

    logic [ALEN-1:0] fetchPc_q, fetchPc_d;
    logic [OW-1:0]   outstanding_q, outstanding_d;
    logic [OW-1:0]   dropCount_q, dropCount_d;
    logic            pendingHalf_q, pendingHalf_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   rdPtr_q, rdPtr_d, wrPtr_q, wrPtr_d;
    logic [AW-1:0]   addrRd_q, addrRd_d, addrWr_q, addrWr_d;

    logic [ALEN-1:0] addrMem_q  [MAX_OUTSTANDING];
    logic [ALEN-1:0] entAddr_q  [FIFO_DEPTH];
    logic [31:0]     entData_q  [FIFO_DEPTH];
    logic            entFault_q [FIFO_DEPTH];
    logic            entHalf_q  [FIFO_DEPTH];

    logic [SW-1:0]   inFlight;
    logic            reqFire, respKeep, bypass, push, pop;
    logic [ALEN-1:0] respAddr;
    logic            unusedTargetBit;

    assign unusedTargetBit = redirect_target[0];

    // Counting queued words plus in-flight requests guarantees every response a free slot.
    assign inFlight      = SW'(count_q) + SW'(outstanding_q);
    assign mem_req_valid = !rst && !redirect_valid
                           && (outstanding_q < OW'(MAX_OUTSTANDING))
                           && (inFlight < SW'(FIFO_DEPTH));
    assign mem_req_addr  = fetchPc_q;
    assign reqFire       = mem_req_valid && mem_req_ready;

    assign respAddr = addrMem_q[addrRd_q];
    assign respKeep = mem_resp_valid && !redirect_valid && (dropCount_q == '0);
    assign pop      = (count_q != '0) && out_ready;

`ifdef FETCH_BYPASS_EN
    assign bypass         = !rst && respKeep && (count_q == '0);
    assign push           = respKeep && !(bypass && out_ready);
    assign out_valid      = (count_q != '0) || bypass;
    assign out_addr       = bypass ? respAddr       : entAddr_q[rdPtr_q];
    assign out_data       = bypass ? mem_resp_data  : entData_q[rdPtr_q];
    assign out_fault      = out_valid && (bypass ? mem_resp_error : entFault_q[rdPtr_q]);
    assign out_half_start = out_valid && (bypass ? pendingHalf_q  : entHalf_q[rdPtr_q]);
`else
    assign bypass         = 1'b0;
    assign push           = respKeep;
    assign out_valid      = (count_q != '0);
    assign out_addr       = entAddr_q[rdPtr_q];
    assign out_data       = entData_q[rdPtr_q];
    assign out_fault      = out_valid && entFault_q[rdPtr_q];
    assign out_half_start = out_valid && entHalf_q[rdPtr_q];
`endif

    function automatic logic [AW-1:0] addrNext(input logic [AW-1:0] p);
        return (p == AW'(MAX_OUTSTANDING - 1)) ? '0 : p + AW'(1);
    endfunction

    always_comb begin
        fetchPc_d     = fetchPc_q;
        dropCount_d   = dropCount_q;
        pendingHalf_d = pendingHalf_q;
        count_d       = count_q;
        rdPtr_d       = rdPtr_q;
        wrPtr_d       = wrPtr_q;
        addrRd_d      = addrRd_q;
        addrWr_d      = addrWr_q;
        // A response landing with the redirect is itself stale, so it is not counted as a drop.
        if (redirect_valid) begin
            fetchPc_d     = {redirect_target[ALEN-1:2], 2'b00};
            pendingHalf_d = redirect_target[1];
            dropCount_d   = outstanding_q - OW'(mem_resp_valid);
            count_d       = '0;
            rdPtr_d       = '0;
            wrPtr_d       = '0;
        end else begin
            if (reqFire)
                fetchPc_d = fetchPc_q + ALEN'(4);
            if (mem_resp_valid && (dropCount_q != '0))
                dropCount_d = dropCount_q - OW'(1);
            if (respKeep)
                pendingHalf_d = 1'b0;
            if (push)
                wrPtr_d = wrPtr_q + PW'(1);
            if (pop)
                rdPtr_d = rdPtr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
        outstanding_d = outstanding_q + OW'(reqFire) - OW'(mem_resp_valid);
        if (reqFire)
            addrWr_d = addrNext(addrWr_q);
        if (mem_resp_valid)
            addrRd_d = addrNext(addrRd_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetchPc_q     <= RESET_PC;
            outstanding_q <= '0;
            dropCount_q   <= '0;
            pendingHalf_q <= 1'b0;
            count_q       <= '0;
            rdPtr_q       <= '0;
            wrPtr_q       <= '0;
            addrRd_q      <= '0;
            addrWr_q      <= '0;
        end else begin
            fetchPc_q     <= fetchPc_d;
            outstanding_q <= outstanding_d;
            dropCount_q   <= dropCount_d;
            pendingHalf_q <= pendingHalf_d;
            count_q       <= count_d;
            rdPtr_q       <= rdPtr_d;
            wrPtr_q       <= wrPtr_d;
            addrRd_q      <= addrRd_d;
            addrWr_q      <= addrWr_d;
        end
    end

    // Payload storage needs no reset; validity is carried by the counters above.
    always_ff @(posedge clk) begin
        if (reqFire)
            addrMem_q[addrWr_q] <= fetchPc_q;
        if (push) begin
            entAddr_q[wrPtr_q]  <= respAddr;
            entData_q[wrPtr_q]  <= mem_resp_data;
            entFault_q[wrPtr_q] <= mem_resp_error;
            entHalf_q[wrPtr_q]  <= pendingHalf_q;
        end
    end

endmodule

// File: tb/tb_fetch_pc_queue.sv
// Directed-vector bench for fetch_pc_queue driving a memory that answers one cycle after each request.
// Build with +define+FETCH_BYPASS_EN to expect the same-cycle bypass path.
`timescale 1ns/1ps
module tb_fetch_pc_queue;
    localparam int ALEN = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        mem_resp_error;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_addr;
    logic [31:0] out_data;
    logic        out_half_start;
    logic        out_fault;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        half;
        logic        fault;
    } popRec_t;

    logic [31:0] respQ[$];
    logic [31:0] reqLog[$];
    popRec_t     popLog[$];
    bit          autoResp;
    logic [31:0] faultAddr;
    logic        lastOutValid;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    fetch_pc_queue #(
        .ALEN(ALEN), .RESET_PC(32'h0000_0100), .FIFO_DEPTH(4), .MAX_OUTSTANDING(2)
    ) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_resp_error(mem_resp_error),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
        .out_half_start(out_half_start), .out_fault(out_fault)
    );

    function automatic logic [31:0] dataFor(input logic [31:0] a);
        return a ^ 32'hC3A5_5A3C;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // One clock cycle: present the memory response, log handshakes, advance to the next falling edge.
    task automatic applyStimulus();
        logic [31:0] a;
        popRec_t     rec;
        if (autoResp && respQ.size() > 0) begin
            a              = respQ.pop_front();
            mem_resp_valid = 1'b1;
            mem_resp_data  = dataFor(a);
            mem_resp_error = (a == faultAddr);
        end else begin
            mem_resp_valid = 1'b0;
            mem_resp_data  = '0;
            mem_resp_error = 1'b0;
        end
        #1;
        lastOutValid = out_valid;
        if (mem_req_valid && mem_req_ready) begin
            reqLog.push_back(mem_req_addr);
            respQ.push_back(mem_req_addr);
        end
        if (out_valid && out_ready) begin
            rec.addr  = out_addr;
            rec.data  = out_data;
            rec.half  = out_half_start;
            rec.fault = out_fault;
            popLog.push_back(rec);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus();
    endtask

    task automatic redirectTo(input logic [31:0] target);
        redirect_valid  = 1'b1;
        redirect_target = target;
        applyStimulus();
        redirect_valid  = 1'b0;
    endtask

    task automatic resetDut();
        rst            = 1'b1;
        autoResp       = 1'b0;
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        mem_req_ready  = 1'b0;
        faultAddr      = 32'hFFFF_FFFF;
        respQ.delete();
        runCycles(2);
        #1;
        checkOutput("reset mem_req_valid", {31'b0, mem_req_valid}, 32'd0);
        checkOutput("reset out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("reset out_half_start", {31'b0, out_half_start}, 32'd0);
        checkOutput("reset out_fault", {31'b0, out_fault}, 32'd0);
        rst = 1'b0;
        reqLog.delete();
        popLog.delete();
    endtask

    initial begin
        rst = 1'b1; redirect_valid = 1'b0; redirect_target = '0; mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0; mem_resp_data = '0; mem_resp_error = 1'b0; out_ready = 1'b0;
        autoResp = 1'b0; faultAddr = 32'hFFFF_FFFF; lastOutValid = 1'b0;
        @(negedge clk);

        // Streaming from the reset PC.
        resetDut();
        mem_req_ready = 1'b1; out_ready = 1'b1; autoResp = 1'b1;
        runCycles(8);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("stream req[%0d]", i), reqLog[i], 32'h100 + 32'(4 * i));
            checkOutput($sformatf("stream out_addr[%0d]", i), popLog[i].addr, 32'h100 + 32'(4 * i));
            checkOutput($sformatf("stream out_data[%0d]", i), popLog[i].data, dataFor(32'h100 + 32'(4 * i)));
            checkOutput($sformatf("stream half[%0d]", i), {31'b0, popLog[i].half}, 32'd0);
        end

        // Backpressure: exactly FIFO_DEPTH requests, then one more per popped word.
        resetDut();
        mem_req_ready = 1'b1; autoResp = 1'b1;
        runCycles(10);
        checkOutput("stall req count", reqLog.size(), 32'd4);
        checkOutput("stall mem_req_valid", {31'b0, mem_req_valid}, 32'd0);
        out_ready = 1'b1;
        applyStimulus();
        out_ready = 1'b0;
        runCycles(4);
        checkOutput("refill req count", reqLog.size(), 32'd5);
        checkOutput("refill req addr", reqLog[4], 32'h110);
        checkOutput("refill pop addr", popLog[0].addr, 32'h100);

        // Redirect with two requests in flight, target in the upper halfword.
        resetDut();
        mem_req_ready = 1'b1; out_ready = 1'b1;
        redirectTo(32'h200);
        runCycles(2);
        checkOutput("outstanding req count", reqLog.size(), 32'd2);
        checkOutput("outstanding limit", {31'b0, mem_req_valid}, 32'd0);
        redirectTo(32'h402);
        autoResp = 1'b1;
        runCycles(6);
        checkOutput("redirect req addr", reqLog[2], 32'h400);
        checkOutput("redirect out_addr", popLog[0].addr, 32'h400);
        checkOutput("redirect out_data", popLog[0].data, dataFor(32'h400));
        checkOutput("redirect half", {31'b0, popLog[0].half}, 32'd1);
        checkOutput("redirect next addr", popLog[1].addr, 32'h404);
        checkOutput("redirect next half", {31'b0, popLog[1].half}, 32'd0);

        // Redirect in the same cycle as the only outstanding response.
        resetDut();
        mem_req_ready = 1'b1; out_ready = 1'b1;
        applyStimulus();
        autoResp = 1'b1;
        redirectTo(32'h600);
        runCycles(4);
        checkOutput("same-cycle req addr", reqLog[1], 32'h600);
        checkOutput("same-cycle out_addr", popLog[0].addr, 32'h600);
        checkOutput("same-cycle out_data", popLog[0].data, dataFor(32'h600));

        // Back-to-back redirects: the second sees a response and one remaining stale word.
        resetDut();
        mem_req_ready = 1'b1; out_ready = 1'b1;
        runCycles(2);
        redirectTo(32'h700);
        autoResp = 1'b1;
        redirectTo(32'h800);
        runCycles(6);
        checkOutput("b2b req addr", reqLog[2], 32'h800);
        checkOutput("b2b out_addr", popLog[0].addr, 32'h800);
        checkOutput("b2b out_data", popLog[0].data, dataFor(32'h800));

        // Access fault travels with its entry only.
        resetDut();
        mem_req_ready = 1'b1; out_ready = 1'b1; faultAddr = 32'h300;
        redirectTo(32'h300);
        autoResp = 1'b1;
        runCycles(6);
        checkOutput("fault out_addr", popLog[0].addr, 32'h300);
        checkOutput("fault flag", {31'b0, popLog[0].fault}, 32'd1);
        checkOutput("fault next addr", popLog[1].addr, 32'h304);
        checkOutput("fault next flag", {31'b0, popLog[1].fault}, 32'd0);

        // Address wrap and response-to-output latency.
        resetDut();
        mem_req_ready = 1'b1; out_ready = 1'b1;
        redirectTo(32'hFFFF_FFFC);
        autoResp = 1'b1;
        applyStimulus();
        applyStimulus();
`ifdef FETCH_BYPASS_EN
        checkOutput("latency resp cycle", {31'b0, lastOutValid}, 32'd1);
`else
        checkOutput("latency resp cycle", {31'b0, lastOutValid}, 32'd0);
`endif
        applyStimulus();
        checkOutput("latency next cycle", {31'b0, lastOutValid}, 32'd1);
        runCycles(3);
        checkOutput("wrap req[0]", reqLog[0], 32'hFFFF_FFFC);
        checkOutput("wrap req[1]", reqLog[1], 32'h0000_0000);
        checkOutput("wrap out_addr[0]", popLog[0].addr, 32'hFFFF_FFFC);
        checkOutput("wrap out_addr[1]", popLog[1].addr, 32'h0000_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
